// File: rtl/top.sv
// Self-stimulating LFSR/accumulator datapath with run-length stop and parity integrity check.
// Optional simulation trace of each active cycle when TOP_TRACE_EN is defined.
module top #(
  parameter int                 WIDTH      = 16,
  parameter logic [WIDTH-1:0]   LFSR_SEED  = 16'hACE1,
  parameter int                 RUN_CYCLES = 8
) (
  input  logic             clock,
  input  logic             reset,
  output logic [7:0]       cycle_cnt,
  output logic [WIDTH-1:0] lfsr_q,
  output logic [WIDTH-1:0] acc_q,
  output logic             done,
  output logic             err
);

  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  localparam logic [WIDTH-1:0] TAP_MASK = 16'hB400;
  localparam logic [7:0]       RUN_LAST = 8'(RUN_CYCLES);

  logic             parity_sh;
  logic             lockup;
  logic             parity_bad;
  logic             err_set;
  logic [7:0]       cnt_inc;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] acc_nxt;

  always_comb begin
    lockup     = (lfsr_q == '0);
    cnt_inc    = cycle_cnt + 8'd1;
    parity_bad = ((^acc_q) != parity_sh);
    err_set    = parity_bad || (!done && lockup);
    // a zero LFSR contributes nothing and is replaced by the seed
    acc_nxt    = lockup ? acc_q : acc_q + lfsr_q;
    if (lockup)
      lfsr_nxt = LFSR_SEED;
    else
      lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAP_MASK : '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      lfsr_q    <= LFSR_SEED;
      acc_q     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      parity_sh <= 1'b0;
    end else begin
      if (err_set)
        err <= 1'b1;
      if (!done) begin
        acc_q     <= acc_nxt;
        lfsr_q    <= lfsr_nxt;
        cycle_cnt <= cnt_inc;
        parity_sh <= ^acc_nxt;
        if (cnt_inc == RUN_LAST)
          done <= 1'b1;
      end
    end
  end

`ifdef TOP_TRACE_EN
  always @(posedge clock) begin
    if (reset) begin
      if (!done)
        $display("top: cycle_cnt=%0d lfsr_q=%h acc_q=%h", cycle_cnt, lfsr_q, acc_q);
      if (!done && cnt_inc == RUN_LAST)
        $display("top: run complete after %0d cycles", RUN_CYCLES);
      if (!err && err_set)
        $display("top: integrity error raised");
    end
  end
`else
`endif

endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for top: reset, LFSR/accumulator sequence, completion, async reset, lock-up, parity.
module tb_top;
  logic        clock;
  logic        reset;
  logic [7:0]  cycle_cnt;
  logic [15:0] lfsr_q;
  logic [15:0] acc_q;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_lfsr [8] = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E,
                                16'h0E27, 16'hB313, 16'hED89, 16'hC2C4};
  logic [15:0] exp_acc  [8] = '{16'hACE1, 16'h8F51, 16'h0089, 16'h3925,
                                16'h5573, 16'h639A, 16'h16AD, 16'h0436};

  top dut (
    .clock    (clock),
    .reset    (reset),
    .cycle_cnt(cycle_cnt),
    .lfsr_q   (lfsr_q),
    .acc_q    (acc_q),
    .done     (done),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    step();
    step();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({cycle_cnt, lfsr_q, acc_q, done, err} !== {8'd0, 16'hACE1, 16'h0000, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold[%0d] got cnt=%0d lfsr=%h acc=%h done=%b err=%b exp cnt=0 lfsr=ace1 acc=0000 done=0 err=0",
                 i, cycle_cnt, lfsr_q, acc_q, done, err);
      end
    end
  endtask

  task automatic test_sequence();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({cycle_cnt, lfsr_q, acc_q, done} !== {8'(i + 1), exp_lfsr[i], exp_acc[i], 1'b0}) begin
        errors++;
        $display("FAIL seq[%0d] got cnt=%0d lfsr=%h acc=%h done=%b exp cnt=%0d lfsr=%h acc=%h done=0",
                 i, cycle_cnt, lfsr_q, acc_q, done, i + 1, exp_lfsr[i], exp_acc[i]);
      end
    end
  endtask

  task automatic test_completion();
    for (int i = 4; i < 8; i++) begin
      step();
      checks++;
      if ({cycle_cnt, lfsr_q, acc_q, done} !== {8'(i + 1), exp_lfsr[i], exp_acc[i], (i == 7)}) begin
        errors++;
        $display("FAIL run[%0d] got cnt=%0d lfsr=%h acc=%h done=%b exp cnt=%0d lfsr=%h acc=%h done=%b",
                 i, cycle_cnt, lfsr_q, acc_q, done, i + 1, exp_lfsr[i], exp_acc[i], (i == 7));
      end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({cycle_cnt, lfsr_q, acc_q, done, err} !== {8'd8, 16'hC2C4, 16'h0436, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL frozen[%0d] got cnt=%0d lfsr=%h acc=%h done=%b err=%b exp cnt=8 lfsr=c2c4 acc=0436 done=1 err=0",
                 i, cycle_cnt, lfsr_q, acc_q, done, err);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step();
    step();
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({cycle_cnt, lfsr_q, acc_q, done, err} !== {8'd0, 16'hACE1, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got cnt=%0d lfsr=%h acc=%h done=%b err=%b exp cnt=0 lfsr=ace1 acc=0000",
               cycle_cnt, lfsr_q, acc_q, done, err);
    end
    step();
    step();
    checks++;
    if ({cycle_cnt, lfsr_q, acc_q} !== {8'd0, 16'hACE1, 16'h0000}) begin
      errors++;
      $display("FAIL reset_held got cnt=%0d lfsr=%h acc=%h exp cnt=0 lfsr=ace1 acc=0000", cycle_cnt, lfsr_q, acc_q);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({cycle_cnt, lfsr_q, acc_q} !== {8'(i + 1), exp_lfsr[i], exp_acc[i]}) begin
        errors++;
        $display("FAIL restart[%0d] got cnt=%0d lfsr=%h acc=%h exp cnt=%0d lfsr=%h acc=%h",
                 i, cycle_cnt, lfsr_q, acc_q, i + 1, exp_lfsr[i], exp_acc[i]);
      end
    end
  endtask

  task automatic test_lockup();
    apply_reset();
    step();
    step();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL lockup_pre_err got %b exp 0", err);
    end
    @(negedge clock);
    force dut.lfsr_q = 16'h0000;
    #1;
    release dut.lfsr_q;
    step();
    checks++;
    if ({lfsr_q, acc_q, err} !== {16'hACE1, 16'h8F51, 1'b1}) begin
      errors++;
      $display("FAIL lockup got lfsr=%h acc=%h err=%b exp lfsr=ace1 acc=8f51 err=1", lfsr_q, acc_q, err);
    end
    step();
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL lockup_sticky got err=%b exp 1", err);
    end
  endtask

  task automatic test_parity();
    apply_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL parity_reset_err got %b exp 0", err);
    end
    step();
    step();
    @(negedge clock);
    force dut.acc_q = 16'h8F50;
    #1;
    release dut.acc_q;
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL parity_flip got err=%b exp 1", err);
    end
    step();
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL parity_sticky got err=%b exp 1", err);
    end
    apply_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared got %b exp 0", err);
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_sequence();
    test_completion();
    test_async_reset();
    test_lockup();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
